// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time, fixed wait-state latency.
// Optional MISALIGN_TRAP_EN: misaligned accesses respond with Error=1, no store.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        MemoryRead,
  input  logic        MemoryWrite,
  input  logic [63:0] Address,
  input  logic [63:0] WriteData,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [63:0] ReadData,
  output logic        Error
);

  localparam int AW = $clog2(DEPTH);
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [7:0] CNT_INIT =
    8'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        rd_q;
  logic        wr_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic        resp_valid_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic [63:0] mem_q [DEPTH];

  logic          accept;
  logic          commit;
  logic          c_rd;
  logic          c_wr;
  logic [63:0]   c_addr;
  logic [63:0]   c_wdata;
  logic [AW-1:0] c_idx;
  logic          c_inrange;
  logic          c_mis;
  logic [63:0]   c_rdata;
  logic          c_we;

  assign ReqReady  = (state_q == IDLE);
  assign RespValid = resp_valid_q;
  assign ReadData  = rdata_q;
  assign Error     = err_q;

  assign accept = ReqReady & ReqValid;

  // The commit edge is either the accept edge itself (no wait states)
  // or the last WAIT edge; operands come from the live inputs or the latches.
  assign commit = (NO_WAIT & accept)
                | ((state_q == WAIT) & (cnt_q == 8'd0));

  assign c_rd    = ReqReady ? MemoryRead  : rd_q;
  assign c_wr    = ReqReady ? MemoryWrite : wr_q;
  assign c_addr  = ReqReady ? Address     : addr_q;
  assign c_wdata = ReqReady ? WriteData   : wdata_q;

  assign c_idx     = c_addr[AW+2:3];
  assign c_inrange = (c_addr[63:AW+3] == '0);

`ifdef MISALIGN_TRAP_EN
  assign c_mis = |c_addr[2:0];
`else
  logic unused_lsb;
  assign unused_lsb = ^c_addr[2:0];
  assign c_mis      = 1'b0;
`endif

  assign c_rdata = (c_rd && c_inrange && !c_mis) ? mem_q[c_idx] : '0;
  assign c_we    = commit & c_wr & c_inrange & ~c_mis;

  // Request/response sequencing with registered response outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ReqValid) begin
            rd_q    <= MemoryRead;
            wr_q    <= MemoryWrite;
            addr_q  <= Address;
            wdata_q <= WriteData;
            if (NO_WAIT) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              rdata_q      <= c_rdata;
              err_q        <= c_mis;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 8'd0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            rdata_q      <= c_rdata;
            err_q        <= c_mis;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        RESP: begin
          if (RespReady) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage write on the commit edge; never cleared, blocked by reset.
  always_ff @(posedge CLK) begin
    if (!reset && c_we) begin
      mem_q[c_idx] <= c_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: random traffic against a word-array model.
// Two instances: WAIT_CYCLES=2 (main) and WAIT_CYCLES=0.
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int WAITC = 2;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ReqValid, ReqReady, MemoryRead, MemoryWrite;
  logic [63:0] Address, WriteData, ReadData;
  logic        RespValid, RespReady, Error;

  logic        ReqValid0, ReqReady0, MemoryRead0, MemoryWrite0;
  logic [63:0] Address0, WriteData0, ReadData0;
  logic        RespValid0, RespReady0, Error0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] mm [DEPTH];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .CLK(clk), .reset(reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite),
    .Address(Address), .WriteData(WriteData),
    .RespValid(RespValid), .RespReady(RespReady),
    .ReadData(ReadData), .Error(Error)
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .CLK(clk), .reset(reset),
    .ReqValid(ReqValid0), .ReqReady(ReqReady0),
    .MemoryRead(MemoryRead0), .MemoryWrite(MemoryWrite0),
    .Address(Address0), .WriteData(WriteData0),
    .RespValid(RespValid0), .RespReady(RespReady0),
    .ReadData(ReadData0), .Error(Error0)
  );

  task automatic model_op(input logic rd, input logic wr,
                          input logic [63:0] a, input logic [63:0] wd,
                          output logic [63:0] ed, output logic ee);
    bit mis;
    bit inr;
    int i;
    mis = TRAP && (a % 8 != 0);
    inr = a < 64'(DEPTH * 8);
    i   = int'((a / 8) % DEPTH);
    ed  = '0;
    ee  = mis;
    if (inr && !mis) begin
      if (rd) ed = mm[i];
      if (wr) mm[i] = wd;
    end
  endtask

  task automatic scramble();
    MemoryRead  = 1'($urandom);
    MemoryWrite = 1'($urandom);
    Address     = {$urandom, $urandom};
    WriteData   = {$urandom, $urandom};
  endtask

  task automatic do_txn(input logic rd, input logic wr,
                        input logic [63:0] a, input logic [63:0] wd,
                        output logic [63:0] d, output logic e,
                        output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ReqReady && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    ReqValid = 1'b1; MemoryRead = rd; MemoryWrite = wr;
    Address = a; WriteData = wd;
    @(posedge clk); #1;
    ReqValid = 1'b0;
    scramble();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!RespValid && lat < 300);
    d = ReadData;
    e = Error;
    RespReady = 1'b1;
    @(posedge clk); #1;
    RespReady = 1'b0;
  endtask

  task automatic do_txn0(input logic rd, input logic wr,
                         input logic [63:0] a, input logic [63:0] wd,
                         output logic [63:0] d, output logic e,
                         output int lat);
    @(negedge clk);
    ReqValid0 = 1'b1; MemoryRead0 = rd; MemoryWrite0 = wr;
    Address0 = a; WriteData0 = wd;
    @(posedge clk); #1;
    ReqValid0 = 1'b0;
    Address0 = {$urandom, $urandom};
    WriteData0 = {$urandom, $urandom};
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!RespValid0 && lat < 300);
    d = ReadData0;
    e = Error0;
    RespReady0 = 1'b1;
    @(posedge clk); #1;
    RespReady0 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (RespValid !== 1'b0 || ReadData !== 64'd0 || Error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h e=%b want 0/0/0",
               RespValid, ReadData, Error);
    end
    @(negedge clk);
    n_checks++;
    if (ReqReady !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_reqready: got %b want 1", ReqReady);
    end
  endtask

  task automatic test_fill();
    logic [63:0] d, ed, wd;
    logic e, ee;
    int lat;
    for (int i = 0; i < DEPTH; i++) begin
      wd = {$urandom, $urandom};
      model_op(1'b0, 1'b1, 64'(i * 8), wd, ed, ee);
      do_txn(1'b0, 1'b1, 64'(i * 8), wd, d, e, lat);
      n_checks++;
      if (d !== ed || e !== ee || lat != WAITC + 1) begin
        n_fail++;
        $display("FAIL fill[%0d]: got d=%h e=%b lat=%0d want %h/%b/%0d",
                 i, d, e, lat, ed, ee, WAITC + 1);
      end
    end
  endtask

  task automatic test_store_load();
    logic [63:0] d, ed;
    logic e, ee;
    int lat;
    model_op(1'b0, 1'b1, 64'h40, 64'hDEADBEEF_01234567, ed, ee);
    do_txn(1'b0, 1'b1, 64'h40, 64'hDEADBEEF_01234567, d, e, lat);
    n_checks++;
    if (lat != 3 || d !== 64'd0) begin
      n_fail++;
      $display("FAIL store_0x40: got lat=%0d d=%h want 3/0", lat, d);
    end
    model_op(1'b1, 1'b0, 64'h40, 64'd0, ed, ee);
    do_txn(1'b1, 1'b0, 64'h40, 64'd0, d, e, lat);
    n_checks++;
    if (lat != 3 || d !== 64'hDEADBEEF_01234567 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL load_0x40: got lat=%0d d=%h e=%b want 3/%h/0",
               lat, d, e, 64'hDEADBEEF_01234567);
    end
  endtask

  task automatic test_hold();
    logic [63:0] d, ed, first;
    logic e, ee;
    int lat;
    logic [63:0] a;
    a = 64'($urandom_range(0, DEPTH - 1) * 8);
    model_op(1'b1, 1'b0, a, 64'd0, ed, ee);
    @(negedge clk);
    ReqValid = 1'b1; MemoryRead = 1'b1; MemoryWrite = 1'b0; Address = a;
    @(posedge clk); #1;
    ReqValid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!RespValid && lat < 300);
    first = ReadData;
    n_checks++;
    if (first !== ed || lat != WAITC + 1) begin
      n_fail++;
      $display("FAIL hold_first: got d=%h lat=%0d want %h/%0d",
               first, lat, ed, WAITC + 1);
    end
    for (int i = 0; i < 5; i++) begin
      ReqValid = i[0]; MemoryRead = 1'b0; MemoryWrite = 1'b1;
      Address = a; WriteData = ~first;
      @(negedge clk);
      n_checks++;
      if (RespValid !== 1'b1 || ReadData !== first || ReqReady !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d]: got v=%b d=%h rr=%b want 1/%h/0",
                 i, RespValid, ReadData, ReqReady, first);
      end
    end
    ReqValid = 1'b0;
    RespReady = 1'b1;
    @(posedge clk); #1;
    RespReady = 1'b0;
    model_op(1'b1, 1'b0, a, 64'd0, ed, ee);
    do_txn(1'b1, 1'b0, a, 64'd0, d, e, lat);
    n_checks++;
    if (d !== ed) begin
      n_fail++;
      $display("FAIL hold_ignored_store: got %h want %h", d, ed);
    end
  endtask

  task automatic test_out_of_range();
    logic [63:0] d, ed;
    logic e, ee;
    int lat;
    model_op(1'b0, 1'b1, 64'h1_0000_0000, 64'hCAFE, ed, ee);
    do_txn(1'b0, 1'b1, 64'h1_0000_0000, 64'hCAFE, d, e, lat);
    model_op(1'b1, 1'b0, 64'h1_0000_0000, 64'd0, ed, ee);
    do_txn(1'b1, 1'b0, 64'h1_0000_0000, 64'd0, d, e, lat);
    n_checks++;
    if (d !== 64'd0 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_load: got d=%h e=%b want 0/0", d, e);
    end
    model_op(1'b1, 1'b0, 64'h0, 64'd0, ed, ee);
    do_txn(1'b1, 1'b0, 64'h0, 64'd0, d, e, lat);
    n_checks++;
    if (d !== ed) begin
      n_fail++;
      $display("FAIL oor_word0: got %h want %h", d, ed);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [63:0] d, ed;
    logic e, ee;
    int lat;
    @(negedge clk);
    ReqValid = 1'b1; MemoryRead = 1'b0; MemoryWrite = 1'b1;
    Address = 64'h8; WriteData = 64'h55;
    @(posedge clk); #1;
    ReqValid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ReqReady !== 1'b1 || RespValid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait_state: got rr=%b v=%b want 1/0",
               ReqReady, RespValid);
    end
    model_op(1'b1, 1'b0, 64'h8, 64'd0, ed, ee);
    do_txn(1'b1, 1'b0, 64'h8, 64'd0, d, e, lat);
    n_checks++;
    if (d !== ed) begin
      n_fail++;
      $display("FAIL rst_wait_load: got %h want %h", d, ed);
    end
  endtask

  task automatic test_misalign();
    logic [63:0] d, ed;
    logic e, ee;
    int lat;
    model_op(1'b1, 1'b0, 64'h43, 64'd0, ed, ee);
    do_txn(1'b1, 1'b0, 64'h43, 64'd0, d, e, lat);
    n_checks++;
    if (d !== ed || e !== ee || lat != WAITC + 1) begin
      n_fail++;
      $display("FAIL misalign_load: got d=%h e=%b lat=%0d want %h/%b/%0d",
               d, e, lat, ed, ee, WAITC + 1);
    end
    model_op(1'b0, 1'b1, 64'h45, 64'h1234_5678_9ABC_DEF0, ed, ee);
    do_txn(1'b0, 1'b1, 64'h45, 64'h1234_5678_9ABC_DEF0, d, e, lat);
    n_checks++;
    if (d !== ed || e !== ee) begin
      n_fail++;
      $display("FAIL misalign_store: got d=%h e=%b want %h/%b",
               d, e, ed, ee);
    end
    model_op(1'b1, 1'b0, 64'h40, 64'd0, ed, ee);
    do_txn(1'b1, 1'b0, 64'h40, 64'd0, d, e, lat);
    n_checks++;
    if (d !== ed || e !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_after: got d=%h e=%b want %h/0", d, e, ed);
    end
  endtask

  task automatic test_opcodes();
    logic [63:0] d, ed, wd, a;
    logic e, ee;
    int lat;
    a  = 64'($urandom_range(0, DEPTH - 1) * 8);
    wd = {$urandom, $urandom};
    model_op(1'b1, 1'b1, a, wd, ed, ee);
    do_txn(1'b1, 1'b1, a, wd, d, e, lat);
    n_checks++;
    if (d !== ed) begin
      n_fail++;
      $display("FAIL rw_prewrite: got %h want %h", d, ed);
    end
    model_op(1'b1, 1'b0, a, 64'd0, ed, ee);
    do_txn(1'b1, 1'b0, a, 64'd0, d, e, lat);
    n_checks++;
    if (d !== wd) begin
      n_fail++;
      $display("FAIL rw_written: got %h want %h", d, wd);
    end
    model_op(1'b0, 1'b0, a, ~wd, ed, ee);
    do_txn(1'b0, 1'b0, a, ~wd, d, e, lat);
    n_checks++;
    if (d !== 64'd0 || lat != WAITC + 1) begin
      n_fail++;
      $display("FAIL noop: got d=%h lat=%0d want 0/%0d", d, lat, WAITC + 1);
    end
  endtask

  task automatic test_random();
    logic [63:0] d, ed, wd, a;
    logic e, ee, rd, wr;
    int lat, kind;
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      a = 64'($urandom_range(0, DEPTH - 1) * 8);
      if (kind == 0) a = a | (64'd1 << $urandom_range(11, 63));
      if (kind == 1) a = a + 64'($urandom_range(1, 7));
      rd = 1'($urandom);
      wr = 1'($urandom);
      wd = {$urandom, $urandom};
      model_op(rd, wr, a, wd, ed, ee);
      do_txn(rd, wr, a, wd, d, e, lat);
      n_checks++;
      if (d !== ed || e !== ee || lat != WAITC + 1) begin
        n_fail++;
        $display("FAIL rand[%0d] a=%h r=%b w=%b: got %h/%b/%0d want %h/%b/%0d",
                 n, a, rd, wr, d, e, lat, ed, ee, WAITC + 1);
      end
    end
  endtask

  task automatic test_zero_wait();
    logic [63:0] d, ed;
    logic e;
    int lat;
    do_txn0(1'b0, 1'b1, 64'h10, 64'hA5A5_0000_FFFF_1111, d, e, lat);
    n_checks++;
    if (lat != 1 || d !== 64'd0) begin
      n_fail++;
      $display("FAIL zw_store: got lat=%0d d=%h want 1/0", lat, d);
    end
    do_txn0(1'b1, 1'b0, 64'h10, 64'd0, d, e, lat);
    n_checks++;
    if (lat != 1 || d !== 64'hA5A5_0000_FFFF_1111 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_load: got lat=%0d d=%h e=%b want 1/%h/0",
               lat, d, e, 64'hA5A5_0000_FFFF_1111);
    end
    ed = TRAP ? 64'd0 : 64'hA5A5_0000_FFFF_1111;
    do_txn0(1'b1, 1'b0, 64'h13, 64'd0, d, e, lat);
    n_checks++;
    if (lat != 1 || d !== ed || e !== TRAP) begin
      n_fail++;
      $display("FAIL zw_misalign: got lat=%0d d=%h e=%b want 1/%h/%b",
               lat, d, e, ed, TRAP);
    end
  endtask

  initial begin
    reset = 1'b1;
    ReqValid = 1'b0; RespReady = 1'b0;
    MemoryRead = 1'b0; MemoryWrite = 1'b0;
    Address = '0; WriteData = '0;
    ReqValid0 = 1'b0; RespReady0 = 1'b0;
    MemoryRead0 = 1'b0; MemoryWrite0 = 1'b0;
    Address0 = '0; WriteData0 = '0;
    test_reset();
    test_fill();
    test_store_load();
    test_hold();
    test_out_of_range();
    test_reset_in_wait();
    test_misalign();
    test_opcodes();
    test_random();
    test_zero_wait();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
